// File: rtl/load_store_unit.sv
// Memory-access stage: turns loads/stores into word-addressed RAM transactions with byte strobes,
// lane-extracts load data, and forwards non-memory results to writeback one cycle later.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_wr_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;

    logic [1:0]  state;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;

    logic        accept;
    logic        mem_op;
    logic        load_f3_ok;
    logic        store_f3_ok;
    logic        misaligned;
    logic        bad_op;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Handshake: a transfer happens on a rising edge where ex_valid && ex_ready; ready only in IDLE.
    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign mem_op   = ex_is_load || ex_is_store;

    always_comb begin
        load_f3_ok  = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010)
                   || (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
        store_f3_ok = !ex_funct3[2] && (ex_funct3[1:0] != 2'b11);
        misaligned  = ((ex_funct3[1:0] == 2'b01) && ex_result[0])
                   || ((ex_funct3[1:0] == 2'b10) && (ex_result[1:0] != 2'b00));
        bad_op      = (ex_is_load && ex_is_store) || (ex_is_load && !load_f3_ok)
                   || (ex_is_store && !store_f3_ok) || misaligned;
    end

    always_comb begin
        st_wdata = ex_store_data;
        st_wstrb = 4'b1111;
        case (ex_funct3[1:0])
            2'b00: begin
                st_wdata = {4{ex_store_data[7:0]}};
                st_wstrb = 4'b0001 << ex_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_store_data[15:0]}};
                st_wstrb = 4'b0011 << ex_result[1:0];
            end
            default: begin
                st_wdata = ex_store_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_q      <= 5'd0;
            funct3_q  <= 3'd0;
            offset_q  <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            wb_valid  <= 1'b0;
            wb_wr_en  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
            fault     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_wr_en <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!mem_op) begin
                            wb_valid <= 1'b1;
                            wb_wr_en <= (ex_rd != 5'd0);
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_result;
                        end else if (bad_op) begin
                            wb_valid <= 1'b1;
                            fault    <= 1'b1;
                            wb_rd    <= ex_rd;
                            wb_data  <= 32'd0;
                        end else begin
                            rd_q      <= ex_rd;
                            funct3_q  <= ex_funct3;
                            offset_q  <= ex_result[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= ex_is_store;
                            mem_addr  <= {ex_result[31:2], 2'b00};
                            mem_wdata <= ex_is_store ? st_wdata : 32'd0;
                            mem_wstrb <= ex_is_store ? st_wstrb : 4'b0000;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Request fields stay frozen until the grant edge, then all clear together.
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_wstrb <= 4'd0;
                        if (mem_we) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= 32'd0;
                            state    <= IDLE;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_wr_en <= (rd_q != 5'd0);
                        wb_rd    <= rd_q;
                        wb_data  <= load_data;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs driven and outputs sampled 1ns after each rising edge.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_wr_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  int checks;
  int failures;

  load_store_unit dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0;
    ex_result = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_result = addr; ex_store_data = sdata; ex_rd = rd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_wren"}, {31'd0, wb_wr_en}, 32'd0);
    check({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
    check({tag, "_wbdata"}, wb_data, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
  endtask

  // Load with immediate grant and immediate read data; wb expected in cycle 3.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp_data);
    drive_op(1'b1, 1'b0, f3, addr, 32'd0, 5'd7);
    step();
    ex_valid = 1'b0;
    check({tag, "_c1_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_c1_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_c1_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, "_c1_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    check({tag, "_c1_ready"}, {31'd0, ex_ready}, 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check({tag, "_c2_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_c2_wbv"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_c2_ready"}, {31'd0, ex_ready}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0;
    check({tag, "_c3_wbv"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_c3_data"}, wb_data, exp_data);
    check({tag, "_c3_wren"}, {31'd0, wb_wr_en}, 32'd1);
    check({tag, "_c3_rd"}, {27'd0, wb_rd}, 32'd7);
    check({tag, "_c3_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_c3_ready"}, {31'd0, ex_ready}, 32'd1);
    step();
    check({tag, "_c4_wbv"}, {31'd0, wb_valid}, 32'd0);
  endtask

  // Store with immediate grant; wb expected in cycle 2.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb);
    drive_op(1'b0, 1'b1, f3, addr, sdata, 5'd9);
    step();
    ex_valid = 1'b0;
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    check({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_wren"}, {31'd0, wb_wr_en}, 32'd0);
    check({tag, "_reqlow"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
  endtask

  task automatic do_fault(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr);
    drive_op(ld, st, f3, addr, 32'h5555_5555, 5'd3);
    step();
    ex_valid = 1'b0;
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_fault"}, {31'd0, fault}, 32'd1);
    check({tag, "_wren"}, {31'd0, wb_wr_en}, 32'd0);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
    step();
    check({tag, "_wbv_off"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_fault_off"}, {31'd0, fault}, 32'd0);
    check({tag, "_req_off"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check_all_zero("rst");
    reset = 1'b0;
    step();

    // Reset aborts a pending request; a late rvalid is ignored.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 5'd4);
    step();
    ex_valid = 1'b0;
    check("abort_req_before", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("abort");
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    check("abort_late_rvalid", {31'd0, wb_valid}, 32'd0);
    step();
    check("abort_late_rvalid2", {31'd0, wb_valid}, 32'd0);

    // Back-to-back non-memory ops.
    drive_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd5);
    step();
    drive_op(1'b0, 1'b0, 3'd0, 32'h0000_FFFF, 32'd0, 5'd0);
    check("alu1_wbv", {31'd0, wb_valid}, 32'd1);
    check("alu1_wren", {31'd0, wb_wr_en}, 32'd1);
    check("alu1_data", wb_data, 32'h0000_1234);
    check("alu1_rd", {27'd0, wb_rd}, 32'd5);
    step();
    ex_valid = 1'b0;
    check("alu2_wbv", {31'd0, wb_valid}, 32'd1);
    check("alu2_wren", {31'd0, wb_wr_en}, 32'd0);
    check("alu2_data", wb_data, 32'h0000_FFFF);
    step();
    check("alu_idle_wbv", {31'd0, wb_valid}, 32'd0);

    // SB at 0x103 with a delayed grant; request must hold steady.
    drive_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 5'd2);
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("sb_req", {31'd0, mem_req}, 32'd1);
      check("sb_we", {31'd0, mem_we}, 32'd1);
      check("sb_addr", mem_addr, 32'h0000_0100);
      check("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
      check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      check("sb_wait_wbv", {31'd0, wb_valid}, 32'd0);
      check("sb_wait_ready", {31'd0, ex_ready}, 32'd0);
      if (i == 3) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    check("sb_wbv", {31'd0, wb_valid}, 32'd1);
    check("sb_wren", {31'd0, wb_wr_en}, 32'd0);
    check("sb_reqlow", {31'd0, mem_req}, 32'd0);
    check("sb_ready", {31'd0, ex_ready}, 32'd1);
    step();
    check("sb_wbv_off", {31'd0, wb_valid}, 32'd0);

    do_store("sh", 3'b001, 32'h0000_0102, 32'hFFFF_BEEF, 32'hBEEF_BEEF, 4'b1100);
    do_store("sw", 3'b010, 32'h0000_0204, 32'h1122_3344, 32'h1122_3344, 4'b1111);

    // Loads with lane extraction and extension.
    do_load("lb", 3'b000, 32'h0000_0202, 32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0202, 32'h0080_0000, 32'h0000_0080);
    do_load("lh", 3'b001, 32'h0000_0202, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0202, 32'h8001_0000, 32'h0000_8001);
    do_load("lb1", 3'b000, 32'h0000_0201, 32'h0000_7F00, 32'h0000_007F);
    do_load("lw", 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Faults: no RAM access, wb pulse in cycle 1.
    do_fault("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0301);
    do_fault("ld_f3", 1'b1, 1'b0, 3'b011, 32'h0000_0300);
    do_fault("sh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_0101);
    do_fault("st_f3", 1'b0, 1'b1, 3'b100, 32'h0000_0100);
    do_fault("ld_st", 1'b1, 1'b1, 3'b010, 32'h0000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
